// File: rtl/melody_sequencer.sv
// melody_sequencer: command-driven melody playback controller.
// Fetches 12-bit note words from the melody ROM, holds each note for
// duration x UNIT_CYCLES clocks, inserts GAP_UNITS x UNIT_CYCLES clocks of
// silence after each note, and handles play/stop/pause/loop control.
module melody_sequencer #(
   parameter int ADDR_W      = 5,
   parameter int LAST_ADDR   = 24,
   parameter int UNIT_CYCLES = 1500000,
   parameter int GAP_UNITS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              play,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic [7:0]        note_code,
   output logic              gate,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int GAP_W = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
   localparam bit HAS_GAP = (GAP_UNITS > 0);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(UNIT_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_UNITS > 0) ? GAP_UNITS - 1 : 0);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_GAP
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [7:0]        r_note_code;
   logic              r_gate;
   logic              r_busy;
   logic              r_done;
   logic [CNT_W-1:0]  r_cnt;
   logic [3:0]        r_units;
   logic [GAP_W-1:0]  r_gap;

   logic [3:0] w_dur;
   logic [7:0] w_code;
   logic       w_unit_wrap;
   logic       w_note_end;
   logic       w_gap_end;
   logic       w_advance;
   logic       w_marker;
   logic       w_eos;

   assign w_dur       = rom_data[3:0];
   assign w_code      = rom_data[11:4];
   assign w_unit_wrap = (r_cnt == CNT_LAST);
   // Last counted cycle of the sounding part of a note.
   assign w_note_end  = (r_state == S_PLAY) && !pause && w_unit_wrap && (r_units == 4'd1);
   // Last counted cycle of the silence gap.
   assign w_gap_end   = (r_state == S_GAP) && !pause && w_unit_wrap && (r_gap == GAP_LAST);
   // The note (plus its gap, if any) is finished and the next address is due.
   assign w_advance   = HAS_GAP ? w_gap_end : w_note_end;
   assign w_marker    = (r_state == S_LOAD) && (w_dur == 4'd0);
   // End of song: explicit marker, or finishing the note at the last address.
   assign w_eos       = w_marker || (w_advance && (r_rom_addr == ADDR_LAST));

   assign rom_addr  = r_rom_addr;
   assign note_code = r_note_code;
   assign gate      = r_gate;
   assign busy      = r_busy;
   assign done      = r_done;

   // Playback state machine with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rom_addr  <= '0;
         r_note_code <= '0;
         r_gate      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cnt       <= '0;
         r_units     <= '0;
         r_gap       <= '0;
      end else begin
         r_done <= 1'b0;
         if (stop) begin
            r_state     <= S_IDLE;
            r_rom_addr  <= '0;
            r_note_code <= '0;
            r_gate      <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_units     <= '0;
            r_gap       <= '0;
         end else if (w_eos) begin
            r_done     <= 1'b1;
            r_gate     <= 1'b0;
            r_rom_addr <= '0;
            r_cnt      <= '0;
            r_units    <= '0;
            r_gap      <= '0;
            if (loop_en) begin
               r_state <= S_FETCH;
            end else begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_note_code <= '0;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (play) begin
                     r_state    <= S_FETCH;
                     r_rom_addr <= '0;
                     r_busy     <= 1'b1;
                  end
               end
               S_FETCH: r_state <= S_LOAD;
               S_LOAD: begin
                  // Marker case is handled by the end-of-song branch.
                  r_note_code <= w_code;
                  r_gate      <= (w_code != 8'd0);
                  r_units     <= w_dur;
                  r_cnt       <= '0;
                  r_state     <= S_PLAY;
               end
               S_PLAY: begin
                  if (pause) begin
                     r_gate <= 1'b0;
                  end else if (w_unit_wrap) begin
                     r_cnt <= '0;
                     if (r_units == 4'd1) begin
                        r_gate  <= 1'b0;
                        r_units <= '0;
                        if (HAS_GAP) begin
                           r_state <= S_GAP;
                           r_gap   <= '0;
                        end else begin
                           r_rom_addr <= r_rom_addr + ADDR_W'(1);
                           r_state    <= S_FETCH;
                        end
                     end else begin
                        r_units <= r_units - 4'd1;
                        r_gate  <= (r_note_code != 8'd0);
                     end
                  end else begin
                     r_cnt  <= r_cnt + CNT_W'(1);
                     r_gate <= (r_note_code != 8'd0);
                  end
               end
               S_GAP: begin
                  if (!pause) begin
                     if (w_unit_wrap) begin
                        r_cnt <= '0;
                        if (r_gap == GAP_LAST) begin
                           r_gap      <= '0;
                           r_rom_addr <= r_rom_addr + ADDR_W'(1);
                           r_state    <= S_FETCH;
                        end else begin
                           r_gap <= r_gap + GAP_W'(1);
                        end
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with UNIT_CYCLES=4, GAP_UNITS=1,
// LAST_ADDR=3. Gate-high runs are collected by a monitor and matched
// against expected runs queued when playback is started.
module tb_melody_sequencer;

   localparam int ADDR_W = 5;

   typedef struct {
      logic [7:0] code;
      int         len;
   } run_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              play = 1'b0;
   logic              stop = 1'b0;
   logic              pause = 1'b0;
   logic              loop_en = 1'b0;
   logic [ADDR_W-1:0] rom_addr;
   logic [11:0]       rom_data = 12'h000;
   logic [7:0]        note_code;
   logic              gate;
   logic              busy;
   logic              done;

   logic [11:0] rom [0:31];

   int checks = 0;
   int failures = 0;

   run_t exp_q[$];
   run_t obs_q[$];
   int   run_len = 0;
   logic [7:0] run_code = 8'h00;
   int   done_cnt = 0;
   int   total_hi = 0;
   int   max_addr = 0;

   melody_sequencer #(
      .ADDR_W(ADDR_W),
      .LAST_ADDR(3),
      .UNIT_CYCLES(4),
      .GAP_UNITS(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .play(play),
      .stop(stop),
      .pause(pause),
      .loop_en(loop_en),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .note_code(note_code),
      .gate(gate),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // Melody ROM with one cycle read latency.
   always @(posedge clk) rom_data <= rom[rom_addr];

   // Monitor: gate-high runs, done pulses, highest address seen.
   always @(negedge clk) begin
      if (gate === 1'b1) begin
         run_len  = run_len + 1;
         run_code = note_code;
         total_hi = total_hi + 1;
      end else if (run_len > 0) begin
         obs_q.push_back('{code: run_code, len: run_len});
         run_len = 0;
      end
      if (done === 1'b1) done_cnt = done_cnt + 1;
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_state();
      exp_q.delete();
      obs_q.delete();
      total_hi = 0;
      max_addr = 0;
      for (int i = 0; i < 32; i++) rom[i] = 12'h000;
   endtask

   task automatic pulse_play();
      play = 1'b1;
      tick();
      play = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         play    = i[0];
         stop    = i[1];
         pause   = ~i[0];
         loop_en = 1'b1;
         tick();
         checks++;
         if ({rom_addr, note_code, gate, busy, done} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs cycle=%0d got=%h exp=0000", i, {rom_addr, note_code, gate, busy, done});
         end
      end
      play = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
      #3 rst_n = 1'b1;
      repeat (5) tick();
      checks++;
      if ({busy, gate, rom_addr} !== 7'd0) begin
         failures++;
         $display("FAIL reset_idle got busy=%b gate=%b addr=%0d exp 0/0/0", busy, gate, rom_addr);
      end
      $display("reset: outputs cleared, idle held");
   endtask

   task automatic test_note_rest_marker();
      int cyc;
      clear_state();
      rom[0] = 12'h412;
      rom[1] = 12'h003;
      rom[2] = 12'h000;
      exp_q.push_back('{code: 8'h41, len: 8});
      pulse_play();                               // E0
      checks++;
      if (busy !== 1'b1 || rom_addr !== 5'd0) begin
         failures++;
         $display("FAIL start_fetch got busy=%b addr=%0d exp 1/0", busy, rom_addr);
      end
      tick(); tick();                             // E2
      checks++;
      if (gate !== 1'b1 || note_code !== 8'h41) begin
         failures++;
         $display("FAIL start_latency got gate=%b code=%h exp 1/41", gate, note_code);
      end
      cyc = 2;
      while (rom_addr !== 5'd1 && cyc < 200) begin tick(); cyc++; end
      checks++;
      if (cyc != 14) begin
         failures++;
         $display("FAIL note_period got=%0d exp=14", cyc);
      end
      tick(); tick(); cyc += 2;
      checks++;
      if (note_code !== 8'h00 || gate !== 1'b0) begin
         failures++;
         $display("FAIL rest_note got code=%h gate=%b exp 00/0", note_code, gate);
      end
      while (rom_addr !== 5'd2 && cyc < 200) begin tick(); cyc++; end
      checks++;
      if (cyc != 32) begin
         failures++;
         $display("FAIL rest_period got=%0d exp=32", cyc);
      end
      while (done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
      checks++;
      if (cyc != 34 || busy !== 1'b0 || rom_addr !== 5'd0) begin
         failures++;
         $display("FAIL marker_done got cyc=%0d busy=%b addr=%0d exp 34/0/0", cyc, busy, rom_addr);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL done_width got=%b exp=0", done);
      end
      while (exp_q.size() > 0) begin
         run_t e, o;
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL note_run missing exp code=%h len=%0d", e.code, e.len);
         end else begin
            o = obs_q.pop_front();
            $display("note: code=%h len=%0d", o.code, o.len);
            if (o.code !== e.code || o.len != e.len) begin
               failures++;
               $display("FAIL note_run got code=%h len=%0d exp code=%h len=%0d", o.code, o.len, e.code, e.len);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL rest_silent got extra_runs=%0d exp=0", obs_q.size());
      end

      // Same song in loop mode: done pulses but playback restarts.
      clear_state();
      rom[0] = 12'h412;
      rom[1] = 12'h003;
      rom[2] = 12'h000;
      loop_en = 1'b1;
      pulse_play();
      cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
      checks++;
      if (cyc != 34 || busy !== 1'b1 || rom_addr !== 5'd0) begin
         failures++;
         $display("FAIL loop_done got cyc=%0d busy=%b addr=%0d exp 34/1/0", cyc, busy, rom_addr);
      end
      tick(); tick();
      checks++;
      if (gate !== 1'b1 || note_code !== 8'h41) begin
         failures++;
         $display("FAIL loop_replay got gate=%b code=%h exp 1/41", gate, note_code);
      end
      stop = 1'b1; tick(); stop = 1'b0;
      loop_en = 1'b0;
      repeat (2) tick();
      $display("note/rest/marker and loop replay done");
   endtask

   task automatic test_no_marker();
      int cyc;
      clear_state();
      rom[0] = 12'h111;
      rom[1] = 12'h221;
      rom[2] = 12'h331;
      rom[3] = 12'h441;
      rom[4] = 12'h0FF;
      exp_q.push_back('{code: 8'h11, len: 4});
      exp_q.push_back('{code: 8'h22, len: 4});
      exp_q.push_back('{code: 8'h33, len: 4});
      exp_q.push_back('{code: 8'h44, len: 4});
      pulse_play();
      cyc = 0;
      while (done !== 1'b1 && cyc < 300) begin tick(); cyc++; end
      checks++;
      if (cyc != 40 || busy !== 1'b0) begin
         failures++;
         $display("FAIL last_addr_done got cyc=%0d busy=%b exp 40/0", cyc, busy);
      end
      tick();
      checks++;
      if (max_addr > 3 || rom_addr !== 5'd0) begin
         failures++;
         $display("FAIL addr_bound got max=%0d addr=%0d exp <=3/0", max_addr, rom_addr);
      end
      while (exp_q.size() > 0) begin
         run_t e, o;
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL seq_run missing exp code=%h len=%0d", e.code, e.len);
         end else begin
            o = obs_q.pop_front();
            $display("note: code=%h len=%0d", o.code, o.len);
            if (o.code !== e.code || o.len != e.len) begin
               failures++;
               $display("FAIL seq_run got code=%h len=%0d exp code=%h len=%0d", o.code, o.len, e.code, e.len);
            end
         end
      end
   endtask

   task automatic test_pause();
      int cyc;
      clear_state();
      rom[0] = 12'h412;
      rom[1] = 12'h000;
      pulse_play();                               // E0
      tick(); tick(); tick();                     // E3
      pause = 1'b1;
      tick(); tick();                             // E5
      checks++;
      if (gate !== 1'b0 || note_code !== 8'h41) begin
         failures++;
         $display("FAIL pause_gate got gate=%b code=%h exp 0/41", gate, note_code);
      end
      tick(); tick(); tick();                     // E8
      pause = 1'b0;
      cyc = 8;
      while (done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
      checks++;
      if (cyc != 21) begin
         failures++;
         $display("FAIL pause_period got=%0d exp=21", cyc);
      end
      tick();
      checks++;
      if (total_hi != 8) begin
         failures++;
         $display("FAIL pause_gate_total got=%0d exp=8", total_hi);
      end
      $display("pause: gate-high total=%0d", total_hi);
   endtask

   task automatic test_stop();
      int d0;
      clear_state();
      rom[0] = 12'h412;
      pulse_play();
      repeat (4) tick();                          // E4
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if ({gate, busy, note_code, rom_addr} !== 15'd0) begin
         failures++;
         $display("FAIL stop_clear got gate=%b busy=%b code=%h addr=%0d exp all 0", gate, busy, note_code, rom_addr);
      end
      d0 = done_cnt;
      repeat (20) tick();
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL stop_no_done got dones=%0d busy=%b exp 0/0", done_cnt - d0, busy);
      end
      play = 1'b1; stop = 1'b1;
      tick();
      play = 1'b0; stop = 1'b0;
      repeat (5) tick();
      checks++;
      if (busy !== 1'b0 || gate !== 1'b0) begin
         failures++;
         $display("FAIL play_stop_same got busy=%b gate=%b exp 0/0", busy, gate);
      end
      $display("stop: cleared without done");
   endtask

   task automatic test_async_reset();
      clear_state();
      rom[0] = 12'h412;
      pulse_play();
      repeat (4) tick();
      checks++;
      if (gate !== 1'b1) begin
         failures++;
         $display("FAIL rst_precondition got gate=%b exp=1", gate);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({rom_addr, note_code, gate, busy, done} !== 16'h0000) begin
         failures++;
         $display("FAIL async_reset got=%h exp=0000", {rom_addr, note_code, gate, busy, done});
      end
      #10 rst_n = 1'b1;
      repeat (6) tick();
      checks++;
      if (busy !== 1'b0 || gate !== 1'b0) begin
         failures++;
         $display("FAIL reset_needs_play got busy=%b gate=%b exp 0/0", busy, gate);
      end
      $display("async reset: outputs cleared mid-note");
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 12'h000;
      test_reset();
      test_note_rest_marker();
      test_no_marker();
      test_pause();
      test_stop();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Playback controller that drives the melody note-address path: it fetches note words from the melody ROM, holds each note for a programmable duration, inserts an inter-note silence gap, and handles play/stop/pause/loop control. It sits between the user controls and the tone generator, replacing a free-running fixed-period note counter with a command-driven state machine. It also reads per-note durations and end-of-song markers from the ROM.

## Interface
- ADDR_W, 5, ROM address width.
- LAST_ADDR, 24, highest valid ROM address. Reaching it ends the song even without a marker.
- UNIT_CYCLES, 1500000, clock cycles per duration unit (25 ms at 60 MHz). Must be ≥ 2.
- GAP_UNITS, 1, silent units after each note. 0 means no gap.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- play  in  1  single-cycle start pulse.
- stop  in  1  single-cycle abort pulse.
- pause  in  1  level; freezes playback while high.
- loop_en  in  1  level; restart at address 0 on end-of-song.
- rom_addr  out  ADDR_W  melody ROM address.
- rom_data  in  12  ROM word, valid one cycle after rom_addr. [11:4] = note code (0 = rest); [3:0] = duration in units (0 = end-of-song marker).
- note_code  out  8  current note code to the tone generator.
- gate  out  1  tone enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at each end-of-song.

## Operation
- Reset values:
  - state = IDLE.
  - rom_addr, note_code, gate, busy, done, and all counters = 0.
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE:
  - On play → FETCH with rom_addr = 0.
  - Otherwise hold.
- FETCH: present rom_addr for one cycle, then → LOAD.
- LOAD: sample rom_data.
  - If duration = 0, end-of-song.
  - Otherwise: note_code ← [11:4]; gate ← (code ≠ 0); units_left ← duration; cycle counter ← 0; → PLAY.
- PLAY:
  - The cycle counter counts 0..UNIT_CYCLES-1. Each wrap decrements units_left.
  - When the last unit expires: gate ← 0.
  - Then, if GAP_UNITS > 0, go to GAP. Otherwise advance directly.
- GAP: count GAP_UNITS × UNIT_CYCLES cycles with gate = 0, then advance.
- Advance:
  - If rom_addr = LAST_ADDR, end-of-song.
  - Otherwise rom_addr + 1 → FETCH.
- End-of-song:
  - done pulses for one cycle.
  - If loop_en: rom_addr ← 0 → FETCH; busy stays 1.
  - Else: rom_addr ← 0, note_code ← 0 → IDLE.
- pause (sampled every cycle):
  - In PLAY or GAP it freezes the cycle counter and units_left, and forces gate = 0.
  - note_code is held.
  - When pause falls, counting resumes where it stopped; gate returns to (note_code ≠ 0) in PLAY.
  - pause has no effect in IDLE, FETCH or LOAD.
- stop, from any state: next state IDLE with rom_addr, note_code, gate = 0. No done pulse.
- Priority: rst_n > stop > pause > normal sequencing.
- play while busy is ignored. play and stop in the same cycle: stop wins.
- Width rules:
  - The cycle counter is $clog2(UNIT_CYCLES) bits.
  - units_left is 4 bits. The gap counter is sized for GAP_UNITS.
  - rom_addr increments never exceed LAST_ADDR (no wrap through 2^ADDR_W).

## Timing
- Registered outputs, no combinational input-to-output paths.
- play sampled at edge E0:
  - FETCH after E0, LOAD after E1.
  - gate and note_code update after E2 (2-cycle start latency).
- gate is high exactly duration × UNIT_CYCLES cycles per sounding note, excluding paused cycles.
- Note period = 2 + (duration + GAP_UNITS) × UNIT_CYCLES cycles.
- done asserts in the cycle after the LOAD that sees the marker, or after the final GAP/PLAY cycle of LAST_ADDR.
- rst_n falling mid-note clears all outputs immediately, without waiting for a clock edge. Playback needs a new play after release.

## Test plan
Bench parameters: UNIT_CYCLES=4, GAP_UNITS=1, LAST_ADDR=3.

1. Reset: hold rst_n=0, toggle inputs → all outputs 0. Release, no play → IDLE persists, busy=0.
2. ROM[0]=0x412, play at E0:
   - note_code=0x41 and gate=1 from E2 for exactly 8 cycles.
   - Then 4 gate-low cycles.
   - Then rom_addr=1.
3. ROM[1]=0x003 (rest): gate stays 0 for 12 cycles; note_code=0x00; sequencing continues.
4. ROM[2]=0x000 (marker):
   - loop_en=0 → done 1-cycle pulse, busy=0, rom_addr=0.
   - Repeat with loop_en=1 → done pulses, busy stays 1, rom_addr=0, ROM[0] replays.
5. No marker, ROM[0..3] all duration 1 → after addr 3 gap, done pulses and state returns to IDLE. rom_addr never reaches 4.
6. Mid-note controls on ROM[0]=0x412:
   - pause high for 5 cycles in PLAY → gate low during pause; total gate-high still 8 cycles.
   - stop mid-note → next cycle gate=0, busy=0, no done.
   - play+stop same cycle → stays IDLE.
   - rst_n pulse mid-note → outputs 0 without a clock edge.
